fwft_pack: RTL and testbench

FWFT_PACK -- requirements
Module: fwft_pack

---
 rtl/fwft_pack_pkg.sv | 13 +
 rtl/fwft_pack_ctrl.sv | 73 +++++++
 rtl/fwft_pack.sv | 57 +++++
 tb/tb_fwft_pack.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fwft_pack_pkg.sv
// Shared FIFO constants and types, used by this packer and the asymmetric FIFO.
package fwft_pack_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Which half of the tail word the next accepted write fills.
  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } lane_e;

endpackage

// File: rtl/fwft_pack_ctrl.sv
// Pointer, lane-select and flag logic for the half-word packing FWFT FIFO.
module pack_fifo_ctrl
  import fwft_pack_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  full,
  output logic                  empty,
  output logic                  half_pending,
  output logic                  wr_lo_en,
  output logic                  wr_hi_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  lane_e               hsel_q, hsel_d;
  logic                wr_acc;
  logic                rd_acc;

  // Flags come straight from registered pointers; a half word never counts.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    half_pending = (hsel_q == LANE_HI);
    wr_acc       = wr && !full;
    rd_acc       = rd && !empty;
    wr_lo_en     = wr_acc && (hsel_q == LANE_LO);
    wr_hi_en     = wr_acc && (hsel_q == LANE_HI);
    wr_addr      = wr_ptr_q[ADDR_WIDTH-1:0];
    rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
  end

  // Next-state: lane toggles per accepted half, wr_ptr advances on the high half.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hsel_d   = hsel_q;
    if (wr_acc) begin
      if (hsel_q == LANE_LO) begin
        hsel_d = LANE_HI;
      end else begin
        hsel_d   = LANE_LO;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and lane registers; reset discards any half-written word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hsel_q   <= LANE_LO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hsel_q   <= hsel_d;
    end
  end

endmodule

// File: rtl/fwft_pack.sv
// First-word-fall-through FIFO packing pairs of half-words into full read words.
module fwft_pack
  import fwft_pack_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       wr,
  input  logic [(DATA_WIDTH>>1)-1:0] wr_data,
  output logic                       full,
  input  logic                       rd,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic                       half_pending
);

  localparam int IN_WIDTH = DATA_WIDTH >> 1;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  logic [IN_WIDTH-1:0]   lo_mem [DEPTH];
  logic [IN_WIDTH-1:0]   hi_mem [DEPTH];
  logic                  wr_lo_en;
  logic                  wr_hi_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  pack_fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk          (clk),
    .arst_n       (arst_n),
    .wr           (wr),
    .rd           (rd),
    .full         (full),
    .empty        (empty),
    .half_pending (half_pending),
    .wr_lo_en     (wr_lo_en),
    .wr_hi_en     (wr_hi_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr)
  );

  // Lane storage; not reset, the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_lo_en) lo_mem[wr_addr] <= wr_data;
    if (wr_hi_en) hi_mem[wr_addr] <= wr_data;
  end

  // Head word falls through; forced to zero while empty.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = {hi_mem[rd_addr], lo_mem[rd_addr]};
  end

endmodule

// File: tb/tb_fwft_pack.sv
// Directed self-checking bench for fwft_pack (32-bit read word, 16-word depth).
module tb_fwft_pack;

  logic        clk;
  logic        arst_n;
  logic        wr;
  logic [15:0] wr_data;
  logic        full;
  logic        rd;
  logic [31:0] rd_data;
  logic        empty;
  logic        half_pending;

  int checks = 0;
  int errors = 0;

  fwft_pack #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .wr           (wr),
    .wr_data      (wr_data),
    .full         (full),
    .rd           (rd),
    .rd_data      (rd_data),
    .empty        (empty),
    .half_pending (half_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_half(input logic [15:0] d);
    wr      = 1'b1;
    wr_data = d;
    step();
    wr      = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_w;
  int          wr_half;

  initial begin
    arst_n  = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    wr_data = '0;
    #3;
    // Reset values, before any clock edge.
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_hp", {31'd0, half_pending}, 32'd0);
    check("rst_rdata", rd_data, 32'd0);
    step();
    step();
    check("rst_hold_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    step();

    // Basic pair.
    write_half(16'hBEEF);
    check("p1_hp_hi", {31'd0, half_pending}, 32'd1);
    check("p1_empty_half", {31'd0, empty}, 32'd1);
    check("p1_rdata_half", rd_data, 32'd0);
    write_half(16'hDEAD);
    check("p1_hp_lo", {31'd0, half_pending}, 32'd0);
    check("p1_empty_word", {31'd0, empty}, 32'd0);
    check("p1_rdata", rd_data, 32'hDEADBEEF);
    pop();
    check("p1_empty_after_pop", {31'd0, empty}, 32'd1);
    check("p1_rdata_after_pop", rd_data, 32'd0);

    // Fill with 32 halves.
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("fill_not_full_31", {31'd0, full}, 32'd0);
      write_half(16'(i));
    end
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_hp", {31'd0, half_pending}, 32'd0);
    check("fill_head", rd_data, 32'h00010000);
    write_half(16'h0055);
    check("full_wr_ignored_hp", {31'd0, half_pending}, 32'd0);
    check("full_wr_ignored_full", {31'd0, full}, 32'd1);

    // Read and write together while full: write refused.
    rd      = 1'b1;
    wr      = 1'b1;
    wr_data = 16'h1234;
    step();
    rd      = 1'b0;
    wr      = 1'b0;
    check("rdwr_full_cleared", {31'd0, full}, 32'd0);
    check("rdwr_hp", {31'd0, half_pending}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      exp_w = {16'(2 * i + 1), 16'(2 * i)};
      check($sformatf("drain_%0d", i), rd_data, exp_w);
      check($sformatf("drain_ne_%0d", i), {31'd0, empty}, 32'd0);
      pop();
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_rdata", rd_data, 32'd0);

    // Read while empty does nothing.
    pop();
    check("rd_empty_empty", {31'd0, empty}, 32'd1);
    check("rd_empty_rdata", rd_data, 32'd0);
    write_half(16'h0101);
    write_half(16'h0202);
    check("rd_empty_next", rd_data, 32'h02020101);
    pop();
    check("rd_empty_next_pop", {31'd0, empty}, 32'd1);

    // Reset mid-pair discards the half word.
    write_half(16'hAAAA);
    check("mid_hp", {31'd0, half_pending}, 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    check("mid_rst_hp", {31'd0, half_pending}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    step();
    write_half(16'h1111);
    write_half(16'h2222);
    check("mid_word", rd_data, 32'h22221111);
    pop();
    check("mid_empty", {31'd0, empty}, 32'd1);

    // Stream 100 words with reads whenever a word is available.
    wr_half = 0;
    while (wr_half < 200 || q.size() > 0) begin
      check("st_empty", {31'd0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
      check("st_full", {31'd0, full}, 32'd0);
      if (q.size() > 0) check("st_data", rd_data, q[0]);
      rd = (q.size() > 0);
      wr = (wr_half < 200);
      if (wr_half[0] == 1'b0) wr_data = 16'(wr_half >> 1);
      else                    wr_data = 16'hC000 | 16'(wr_half >> 1);
      step();
      if (rd) void'(q.pop_front());
      if (wr) begin
        if (wr_half[0] == 1'b1)
          q.push_back({16'hC000 | 16'(wr_half >> 1), 16'(wr_half >> 1)});
        wr_half++;
      end
      rd = 1'b0;
      wr = 1'b0;
    end
    check("st_end_empty", {31'd0, empty}, 32'd1);
    check("st_end_hp", {31'd0, half_pending}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
